// File: rtl/reg_access_seq_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: shared definitions for the 8-bit datapath.
//   DATA_W / ADDR_W : operand width and register index width
//   opcode_e        : ALU operation encoding (ADD, SUB, AND, MOV)
//   seq_state_e     : register-access sequencer states
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    MOV = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    EXEC  = 2'b10,
    WRITE = 2'b11
  } seq_state_e;

endpackage

// File: rtl/reg_access_seq_if.sv
// ---------------------------------------------------------------------------
// reg_access_seq_if: bundles the instruction handshake, the register-file
// read/write ports and the sequencer status lines.
//   master : the sequencer (drives read addresses, write port, status)
//   slave  : decode stage + register file (drives instruction, read data)
// ---------------------------------------------------------------------------
interface reg_access_seq_if;
  import cpu_pkg::*;

  // Instruction handshake
  logic              instValid_i;
  logic              instReady_o;
  opcode_e           opcode_i;
  logic [ADDR_W-1:0] rd_i;
  logic [ADDR_W-1:0] rs1_i;
  logic [ADDR_W-1:0] rs2_i;

  // Register-file read ports
  logic [ADDR_W-1:0] sourceReg1_o;
  logic [ADDR_W-1:0] sourceReg2_o;
  logic [DATA_W-1:0] data1_i;
  logic [DATA_W-1:0] data2_i;

  // Register-file write port
  logic [ADDR_W-1:0] destReg_o;
  logic              writeFlag_o;
  logic [DATA_W-1:0] data_o;

  // Status
  logic              done_o;
  logic              carry_o;
  logic              busy_o;

  modport master (
    input  instValid_i, opcode_i, rd_i, rs1_i, rs2_i, data1_i, data2_i,
    output instReady_o, sourceReg1_o, sourceReg2_o, destReg_o, writeFlag_o,
           data_o, done_o, carry_o, busy_o
  );

  modport slave (
    output instValid_i, opcode_i, rd_i, rs1_i, rs2_i, data1_i, data2_i,
    input  instReady_o, sourceReg1_o, sourceReg2_o, destReg_o, writeFlag_o,
           data_o, done_o, carry_o, busy_o
  );

endinterface

// File: rtl/reg_access_seq_alu8.sv
// ---------------------------------------------------------------------------
// alu8: combinational 8-bit ALU.
//   opcode : ADD / SUB / AND / MOV
//   op1    : first operand (the only one MOV uses)
//   op2    : second operand
//   result : op1 <op> op2, modulo 2^DATA_W
//   carry  : ADD carry-out, SUB borrow (op1 < op2), 0 otherwise
// ---------------------------------------------------------------------------
module alu8
  import cpu_pkg::*;
(
  input  opcode_e           opcode,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] diff_s;

  // One extra bit on each side exposes carry-out and borrow in the MSB.
  assign sum_s  = {1'b0, op1} + {1'b0, op2};
  assign diff_s = {1'b0, op1} - {1'b0, op2};

  // Operation select
  always_comb begin
    result = {DATA_W{1'b0}};
    carry  = 1'b0;
    case (opcode)
      ADD: begin
        result = sum_s[DATA_W-1:0];
        carry  = sum_s[DATA_W];
      end
      SUB: begin
        result = diff_s[DATA_W-1:0];
        carry  = diff_s[DATA_W];
      end
      AND: begin
        result = op1 & op2;
        carry  = 1'b0;
      end
      MOV: begin
        result = op1;
        carry  = 1'b0;
      end
      default: begin
        result = {DATA_W{1'b0}};
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_access_seq.sv
// ---------------------------------------------------------------------------
// reg_access_seq: register-file access sequencer.
// Accepts one ALU instruction per handshake, then walks
// IDLE -> READ -> EXEC -> WRITE -> IDLE, one cycle per state:
//   READ  : read addresses stable, operands captured at the end of the cycle
//   EXEC  : ALU result and carry registered at the end of the cycle
//   WRITE : writeFlag_o/done_o high for exactly this cycle
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; abandons any instruction
//   bus   : reg_access_seq_if.master (handshake, register-file ports, status)
// ---------------------------------------------------------------------------
module reg_access_seq
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  reg_access_seq_if.master bus
);

  seq_state_e        state_r;
  opcode_e           opcode_r;
  logic [ADDR_W-1:0] rd_r;
  logic [ADDR_W-1:0] src1_r;
  logic [ADDR_W-1:0] src2_r;
  logic [DATA_W-1:0] op1_r;
  logic [DATA_W-1:0] op2_r;
  logic [DATA_W-1:0] data_r;
  logic              write_r;
  logic              done_r;
  logic              carry_r;

  logic [DATA_W-1:0] alu_result_s;
  logic              alu_carry_s;

  alu8 u_alu8 (
    .opcode (opcode_r),
    .op1    (op1_r),
    .op2    (op2_r),
    .result (alu_result_s),
    .carry  (alu_carry_s)
  );

  // Sequencer FSM with all its registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      opcode_r <= ADD;
      rd_r     <= {ADDR_W{1'b0}};
      src1_r   <= {ADDR_W{1'b0}};
      src2_r   <= {ADDR_W{1'b0}};
      op1_r    <= {DATA_W{1'b0}};
      op2_r    <= {DATA_W{1'b0}};
      data_r   <= {DATA_W{1'b0}};
      write_r  <= 1'b0;
      done_r   <= 1'b0;
      carry_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          write_r <= 1'b0;
          done_r  <= 1'b0;
          // instReady_o is high in IDLE, so instValid_i alone completes the handshake
          if (bus.instValid_i) begin
            opcode_r <= bus.opcode_i;
            rd_r     <= bus.rd_i;
            src1_r   <= bus.rs1_i;
            src2_r   <= bus.rs2_i;
            state_r  <= READ;
          end else begin
            state_r  <= IDLE;
          end
        end
        READ: begin
          op1_r   <= bus.data1_i;
          op2_r   <= bus.data2_i;
          state_r <= EXEC;
        end
        EXEC: begin
          // Results and the write strobe all land on the edge entering WRITE
          data_r  <= alu_result_s;
          carry_r <= alu_carry_s;
          write_r <= 1'b1;
          done_r  <= 1'b1;
          state_r <= WRITE;
        end
        WRITE: begin
          write_r <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          write_r <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.instReady_o  = (state_r == IDLE);
  assign bus.busy_o       = (state_r != IDLE);
  assign bus.sourceReg1_o = src1_r;
  assign bus.sourceReg2_o = src2_r;
  assign bus.destReg_o    = rd_r;
  assign bus.writeFlag_o  = write_r;
  assign bus.data_o       = data_r;
  assign bus.done_o       = done_r;
  assign bus.carry_o      = carry_r;

endmodule

// File: tb/tb_reg_access_seq.sv
// ---------------------------------------------------------------------------
// tb_reg_access_seq: sequencer paired with a behavioural 8x8 register file.
// The driver pushes the expected write (from an arithmetic reference model of
// the register contents) when an instruction is accepted; a separate monitor
// pops and compares on every writeFlag_o cycle.
// ---------------------------------------------------------------------------
module tb_reg_access_seq;
  import cpu_pkg::*;

  typedef struct packed {
    logic [2:0] rd;
    logic [7:0] data;
    logic       carry;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_access_seq_if bus();

  reg_access_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural register file
  logic [7:0] rf [8];
  logic       init_req;
  logic       poke_en;
  logic [2:0] poke_addr;
  logic [7:0] poke_data;

  assign bus.data1_i = rf[bus.sourceReg1_o];
  assign bus.data2_i = rf[bus.sourceReg2_o];

  always @(posedge clk) begin
    if (init_req) begin
      rf[0] <= 8'd8; rf[1] <= 8'd7; rf[2] <= 8'd6; rf[3] <= 8'd1;
      rf[4] <= 8'd4; rf[5] <= 8'd3; rf[6] <= 8'd2; rf[7] <= 8'd1;
    end else if (bus.writeFlag_o) begin
      rf[bus.destReg_o] <= bus.data_o;
    end else if (poke_en) begin
      rf[poke_addr] <= poke_data;
    end
  end

  // Reference model state and scoreboard
  int   m [8];
  int   m_save [8];
  exp_t q [$];
  int   errors = 0;
  int   checks = 0;
  int   writes = 0;
  logic hold_carry = 1'b0;
  exp_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic exp_t model(input int op, input int rd, input int rs1, input int rs2);
    int a, b, r, c;
    exp_t e;
    a = m[rs1];
    b = m[rs2];
    case (op)
      0:       begin r = a + b; c = (r > 255) ? 1 : 0; end
      1:       begin r = a - b; c = (a < b) ? 1 : 0;   end
      2:       begin r = a & b; c = 0;                 end
      default: begin r = a;     c = 0;                 end
    endcase
    r = r & 255;
    m[rd] = r;
    e.rd = rd[2:0];
    e.data = r[7:0];
    e.carry = c[0];
    return e;
  endfunction

  // Monitor: compares every write cycle against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_carry = 1'b0;
      end else begin
        check("done_matches_write", int'(bus.done_o), int'(bus.writeFlag_o));
        if (bus.writeFlag_o) begin
          writes++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got dest=%0d data=0x%0h, expected no write", bus.destReg_o, bus.data_o);
          end else begin
            mon_e = q.pop_front();
            check("destReg", int'(bus.destReg_o), int'(mon_e.rd));
            check("data", int'(bus.data_o), int'(mon_e.data));
            check("carry", int'(bus.carry_o), int'(mon_e.carry));
            hold_carry = mon_e.carry;
          end
        end else begin
          check("carry_hold", int'(bus.carry_o), int'(hold_carry));
        end
      end
    end
  end

  // Offer an instruction from the next falling edge; returns after the accepting edge.
  task automatic issue(input int op, input int rd, input int rs1, input int rs2, output time acc_t);
    int n;
    @(negedge clk);
    bus.instValid_i = 1'b1;
    bus.opcode_i = opcode_e'(op[1:0]);
    bus.rd_i = rd[2:0];
    bus.rs1_i = rs1[2:0];
    bus.rs2_i = rs2[2:0];
    n = 0;
    while (!bus.instReady_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc_t = $time;
    if (!bus.instReady_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got instReady_o=0 for 20 cycles, expected 1");
    end else begin
      q.push_back(model(op, rd, rs1, rs2));
      @(posedge clk);
    end
  endtask

  task automatic release_valid();
    @(negedge clk);
    bus.instValid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending writes, expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic poke(input int addr, input int val);
    @(negedge clk);
    poke_en = 1'b1;
    poke_addr = addr[2:0];
    poke_data = val[7:0];
    m[addr] = val & 255;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic restore_after_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    q.delete();
    for (int i = 0; i < 8; i++) m[i] = m_save[i];
  endtask

  initial begin
    time t0, t1;
    int  w0;
    rst_n = 1'b0;
    init_req = 1'b1;
    poke_en = 1'b0;
    poke_addr = 3'd0;
    poke_data = 8'd0;
    bus.instValid_i = 1'b0;
    bus.opcode_i = ADD;
    bus.rd_i = 3'd0;
    bus.rs1_i = 3'd0;
    bus.rs2_i = 3'd0;
    m[0] = 8; m[1] = 7; m[2] = 6; m[3] = 1; m[4] = 4; m[5] = 3; m[6] = 2; m[7] = 1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_instReady", int'(bus.instReady_o), 1);
    check("rst_writeFlag", int'(bus.writeFlag_o), 0);
    check("rst_done", int'(bus.done_o), 0);
    check("rst_data", int'(bus.data_o), 0);
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_carry", int'(bus.carry_o), 0);
    check("rst_destReg", int'(bus.destReg_o), 0);
    #2 rst_n = 1'b1;
    init_req = 1'b0;

    // Idle with no request
    repeat (10) begin
      @(negedge clk);
      check("idle_busy", int'(bus.busy_o), 0);
    end
    check("idle_no_writes", writes, 0);

    // ADD r2 = r1 + r0
    issue(0, 2, 1, 0, t0);
    release_valid();
    drain();
    check("r2_after_add", int'(rf[2]), 15);

    // SUB with borrow, ADD with wrap
    issue(1, 5, 3, 4, t0);
    release_valid();
    drain();
    poke(6, 255);
    issue(0, 7, 6, 3, t0);
    release_valid();
    drain();
    check("r7_after_wrap", int'(rf[7]), 0);

    // Back-to-back dependency with instValid_i held high
    issue(0, 1, 1, 1, t0);
    issue(3, 0, 1, 5, t1);
    release_valid();
    drain();
    check("accept_spacing", int'((t1 - t0) / 10), 4);
    check("r0_after_mov", int'(rf[0]), 14);

    // Reset during EXEC abandons the instruction
    for (int i = 0; i < 8; i++) m_save[i] = m[i];
    w0 = writes;
    issue(2, 4, 0, 1, t0);
    release_valid();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("exec_rst_ready", int'(bus.instReady_o), 1);
    check("exec_rst_busy", int'(bus.busy_o), 0);
    restore_after_reset();
    repeat (5) @(negedge clk);
    check("exec_rst_no_write", writes - w0, 0);
    check("r4_unchanged", int'(rf[4]), 4);

    // Reset during WRITE clears writeFlag_o before the commit edge
    for (int i = 0; i < 8; i++) m_save[i] = m[i];
    w0 = writes;
    issue(0, 3, 3, 3, t0);
    release_valid();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("write_state_flag", int'(bus.writeFlag_o), 1);
    rst_n = 1'b0;
    #1;
    check("async_clear_flag", int'(bus.writeFlag_o), 0);
    restore_after_reset();
    repeat (3) @(negedge clk);
    check("r3_unchanged", int'(rf[3]), 1);

    // Requests while busy are ignored
    w0 = writes;
    issue(2, 4, 0, 2, t0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.instValid_i = 1'b1;
      bus.opcode_i = opcode_e'(i[1:0] + 2'd1);
      bus.rd_i = 3'($urandom_range(7));
      bus.rs1_i = 3'($urandom_range(7));
      bus.rs2_i = 3'($urandom_range(7));
    end
    @(negedge clk);
    bus.instValid_i = 1'b0;
    drain();
    check("ignored_one_write", writes - w0, 1);

    // Randomized traffic
    for (int i = 0; i < 8; i++) poke(i, int'($urandom_range(255)));
    for (int i = 0; i < 30; i++) begin
      issue(int'($urandom_range(3)), int'($urandom_range(7)), int'($urandom_range(7)),
            int'($urandom_range(7)), t0);
      release_valid();
      repeat ($urandom_range(3)) @(negedge clk);
    end
    drain();
    for (int i = 0; i < 8; i++) check("final_rf", int'(rf[i]), m[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_access_seq.md
# reg_access_seq

Register-file access sequencer for the 8-bit datapath: accepts one decoded ALU instruction at a time over a valid/ready handshake, drives the register file's two read-address ports, captures the operands, computes the result and drives the register file's write port for exactly one cycle. It is the initiator side of the register-file interface and sits between instruction decode and the register file.

## Interface
Parameters:
- DATA_W, 8, operand/result width
- ADDR_W, 3, register index width (8 registers)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- instValid_i  in  1  instruction offered
- instReady_o  out  1  sequencer can accept (IDLE only)
- opcode_i  in  2  00 ADD, 01 SUB, 10 AND, 11 MOV
- rd_i / rs1_i / rs2_i  in  ADDR_W  destination and source indices
- sourceReg1_o / sourceReg2_o  out  ADDR_W  register-file read addresses
- data1_i / data2_i  in  DATA_W  register-file read data (combinational from addresses)
- destReg_o  out  ADDR_W  register-file write address
- writeFlag_o  out  1  register-file write enable
- data_o  out  DATA_W  register-file write data
- done_o  out  1  one-cycle pulse, coincident with the write cycle
- carry_o  out  1  carry/borrow of last completed instruction
- busy_o  out  1  high in every state except IDLE

## Operation
- States: IDLE -> READ -> EXEC -> WRITE -> IDLE, one cycle each; no other transitions.
- IDLE: instReady_o=1. A handshake (instValid_i & instReady_o at a rising edge) latches opcode/rd and loads sourceReg1_o=rs1_i, sourceReg2_o=rs2_i; go to READ. Without a handshake, stay.
- READ: addresses stable; data1_i/data2_i captured into operand registers at the edge ending READ.
- EXEC: ALU result and carry registered at the edge ending EXEC.
- WRITE: writeFlag_o=1, destReg_o=rd, data_o=result, done_o=1; carry_o updates at the edge entering WRITE and holds until the next WRITE.
- Arithmetic, mod 2^DATA_W:
  - ADD: carry = bit DATA_W of the DATA_W+1 sum.
  - SUB: result = op1 - op2; carry = borrow (1 iff op1 < op2 unsigned).
  - AND: carry=0.
  - MOV: result = op1; op2 ignored; carry=0.
- rd equal to rs1/rs2 is legal: reads complete before the write.
- instValid_i outside IDLE is ignored; the offering side must hold the instruction until accepted.
- Reset (any time, including mid-instruction): state -> IDLE, instruction abandoned, no write issued.
- Reset values: instReady_o=1, all other outputs 0.

## Timing
- Accept at edge E0. READ during cycle after E0, EXEC next, WRITE next; the register file commits at edge E3.
- done_o and writeFlag_o are high for exactly the cycle ending at E3.
- Throughput: one instruction per 4 cycles. The earliest next accept is at E4, and it observes the E3 write.
- All outputs are registered, except instReady_o and busy_o, which are decoded directly from the state register.
- rst_n assertion clears writeFlag_o asynchronously within the same cycle.

## Structure
- Shared package cpu_pkg holds:
  - DATA_W and ADDR_W constants
  - opcode_e enum (ADD, SUB, AND, MOV)
  - seq_state_e enum (IDLE, READ, EXEC, WRITE)
- One combinational sub-module, alu8, with inputs (opcode, op1, op2) and outputs (result, carry). It is instantiated once in EXEC and is reusable by the datapath.
- The bench pairs the sequencer with a behavioural 8x8 register file preloaded r0..r7 = 8,7,6,1,4,3,2,1.

## Test plan
- Reset: with rst_n low, check instReady_o=1, writeFlag_o=0, done_o=0, data_o=0, busy_o=0; after release, hold instValid_i=0 for 10 cycles -> state stays IDLE, no writes.
- ADD rd=2, rs1=1, rs2=0 (7+8) -> at E3 writeFlag_o=1, destReg_o=2, data_o=0x0F, carry_o=0; r2=15 afterwards.
- Wrap and borrow:
  - SUB rd=5, rs1=3, rs2=4 (1-4) -> data_o=0xFD, carry_o=1.
  - Preload r6=0xFF, then ADD r7 = r6 + r3 -> data_o=0x00, carry_o=1.
- Dependency: ADD r1 = r1 + r1 (7+7 -> 14), then immediately MOV r0 = r1 -> second write data_o=0x0E; instValid_i held high throughout -> accepts exactly every 4 cycles.
- Reset mid-operation: pulse rst_n low during EXEC of AND r4 = r0 & r1 -> no writeFlag_o pulse; r4 stays 4; instReady_o=1 after reset.
- Ignored request: toggle instValid_i with different opcodes during READ/EXEC/WRITE -> only the originally accepted instruction is written; done_o pulses once.
